// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit:
// funct codes, FSM state encoding and small decode helpers.
package ex_muldiv_pkg;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    localparam logic LOW  = 1'b0;
    localparam logic HIGH = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } md_state_t;

    function automatic logic is_iter_op(input logic [5:0] f);
        return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
               (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [5:0] f);
        return (f == FUNCT_DIV) || (f == FUNCT_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [5:0] f);
        return (f == FUNCT_MULT) || (f == FUNCT_DIV);
    endfunction

endpackage

// File: rtl/ex_muldiv_core.sv
// Iterative datapath: one shift-add (multiply) or restoring step (divide)
// per i_step. Ports: i_load latches operands, o_last flags the final
// iteration, o_hi/o_lo present the sign-corrected result.
module ex_muldiv_core
    import ex_muldiv_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_load,
    input  logic         i_step,
    input  logic         i_is_div,
    input  logic         i_signed,
    input  logic [W-1:0] i_op_a,
    input  logic [W-1:0] i_op_b,
    output logic         o_last,
    output logic [W-1:0] o_hi,
    output logic [W-1:0] o_lo
);

    localparam int CW = $clog2(W) + 1;

    // acc holds the product for multiply, {remainder, quotient} for divide
    logic [2*W-1:0] acc_q;
    logic [W-1:0]   b_q;
    logic [CW-1:0]  cnt_q;
    logic           div_q;
    logic           q_neg_q;
    logic           r_neg_q;

    logic           a_neg;
    logic           b_neg;
    logic [W-1:0]   a_abs;
    logic [W-1:0]   b_abs;

    assign a_neg = i_signed & i_op_a[W-1];
    assign b_neg = i_signed & i_op_b[W-1];
    assign a_abs = a_neg ? -i_op_a : i_op_a;
    assign b_abs = b_neg ? -i_op_b : i_op_b;

    logic [W:0]     msum;
    logic [W-1:0]   maddend;
    logic [W:0]     dshift;
    logic [W:0]     dsub;
    logic [2*W-1:0] acc_step;

    always_comb begin
        maddend = acc_q[0] ? b_q : '0;
        msum    = {1'b0, acc_q[2*W-1:W]} + {1'b0, maddend};
        dshift  = {acc_q[2*W-1:W], acc_q[W-1]};
        dsub    = dshift - {1'b0, b_q};
        acc_step = acc_q;
        if (div_q) begin
            // restore when the trial subtraction goes negative
            if (!dsub[W])
                acc_step = {dsub[W-1:0], acc_q[W-2:0], HIGH};
            else
                acc_step = {dshift[W-1:0], acc_q[W-2:0], LOW};
        end else begin
            acc_step = {msum, acc_q[W-1:1]};
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            acc_q   <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            div_q   <= LOW;
            q_neg_q <= LOW;
            r_neg_q <= LOW;
        end else if (i_load) begin
            // multiplier sits in the low half, multiplicand in b_q
            acc_q   <= {{W{1'b0}}, i_is_div ? a_abs : b_abs};
            b_q     <= i_is_div ? b_abs : a_abs;
            cnt_q   <= '0;
            div_q   <= i_is_div;
            q_neg_q <= a_neg ^ b_neg;
            r_neg_q <= a_neg;
        end else if (i_step) begin
            acc_q <= acc_step;
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign o_last = (cnt_q == CW'(W - 1));

    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix;
    logic [W-1:0]   rem_fix;

    always_comb begin
        prod_fix = q_neg_q ? -acc_q : acc_q;
        quo_fix  = q_neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
        rem_fix  = r_neg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
        o_hi     = div_q ? rem_fix : prod_fix[2*W-1:W];
        o_lo     = div_q ? quo_fix : prod_fix[W-1:0];
    end

endmodule

// File: rtl/ex_muldiv.sv
// Execute-stage MULT/DIV unit owning HI/LO; decodes funct, runs the FSM
// and drives o_stall, o_result(_valid) and the o_hi/o_lo registers.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int BUS_SIZE = 32
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_enable,
    input  logic                i_flush,
    input  logic                i_valid,
    input  logic [5:0]          i_funct,
    input  logic [BUS_SIZE-1:0] i_op_a,
    input  logic [BUS_SIZE-1:0] i_op_b,
    output logic                o_stall,
    output logic [BUS_SIZE-1:0] o_result,
    output logic                o_result_valid,
    output logic [BUS_SIZE-1:0] o_hi,
    output logic [BUS_SIZE-1:0] o_lo
);

    md_state_t           state_q;
    md_state_t           state_d;
    logic [BUS_SIZE-1:0] hi_q;
    logic [BUS_SIZE-1:0] hi_d;
    logic [BUS_SIZE-1:0] lo_q;
    logic [BUS_SIZE-1:0] lo_d;

    logic                core_load;
    logic                core_step;
    logic                core_last;
    logic [BUS_SIZE-1:0] core_hi;
    logic [BUS_SIZE-1:0] core_lo;

    logic is_mfhi;
    logic is_mflo;
    logic is_mthi;
    logic is_mtlo;
    logic is_div;
    logic div_zero;
    logic start;

    assign is_mfhi  = (i_funct == FUNCT_MFHI);
    assign is_mflo  = (i_funct == FUNCT_MFLO);
    assign is_mthi  = (i_funct == FUNCT_MTHI);
    assign is_mtlo  = (i_funct == FUNCT_MTLO);
    assign is_div   = is_div_op(i_funct);
    assign div_zero = is_div & (i_op_b == '0);
    assign start    = is_iter_op(i_funct) & ~div_zero;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        core_load = LOW;
        core_step = LOW;
        if (i_enable) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (i_valid && !i_flush) begin
                        unique case (1'b1)
                            is_mthi: hi_d = i_op_a;
                            is_mtlo: lo_d = i_op_a;
                            // divide by zero completes without iterating
                            div_zero: begin
                                hi_d = i_op_a;
                                lo_d = '1;
                            end
                            start: begin
                                core_load = HIGH;
                                state_d   = ST_RUN;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    if (i_flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        core_step = HIGH;
                        if (core_last)
                            state_d = ST_FIX;
                    end
                end
                ST_FIX: begin
                    state_d = ST_IDLE;
                    if (!i_flush) begin
                        hi_d = core_hi;
                        lo_d = core_lo;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    ex_muldiv_core #(
        .W (BUS_SIZE)
    ) u_core (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_load    (core_load),
        .i_step    (core_step),
        .i_is_div  (is_div),
        .i_signed  (is_signed_op(i_funct)),
        .i_op_a    (i_op_a),
        .i_op_b    (i_op_b),
        .o_last    (core_last),
        .o_hi      (core_hi),
        .o_lo      (core_lo)
    );

    assign o_stall        = (state_q != ST_IDLE);
    assign o_result_valid = ~o_stall & i_valid & (is_mfhi | is_mflo);
    assign o_result       = is_mfhi ? hi_q : (is_mflo ? lo_q : '0);
    assign o_hi           = hi_q;
    assign o_lo           = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: table of MULT/DIV vectors plus
// hand sequences for MT/MF, enable gaps, flush and async reset.
module tb_ex_muldiv;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         flush;
    logic         valid;
    logic [5:0]   funct;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         stall;
    logic [W-1:0] result;
    logic         result_valid;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_vec;
    int n_bad;

    ex_muldiv #(
        .BUS_SIZE (W)
    ) dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_enable       (en),
        .i_flush        (flush),
        .i_valid        (valid),
        .i_funct        (funct),
        .i_op_a         (op_a),
        .i_op_b         (op_b),
        .o_stall        (stall),
        .o_result       (result),
        .o_result_valid (result_valid),
        .o_hi           (hi),
        .o_lo           (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]   funct;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           stall;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // issue one op for a single edge, then count stalled cycles
    task automatic run_op(input logic [5:0] f, input logic [W-1:0] a,
                          input logic [W-1:0] b, output int cyc);
        @(negedge clk);
        valid = 1'b1;
        funct = f;
        op_a  = a;
        op_b  = b;
        @(negedge clk);
        valid = 1'b0;
        cyc = 0;
        while (stall && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    initial begin
        int cyc;
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        en    = 1'b1;
        flush = 1'b0;
        valid = 1'b0;
        funct = 6'h00;
        op_a  = '0;
        op_b  = '0;

        vecs[0] = '{6'h18, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA, 33};
        vecs[1] = '{6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 33};
        vecs[2] = '{6'h1A, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
        vecs[3] = '{6'h1B, 32'h7, 32'h0, 32'h7, 32'hFFFFFFFF, 0};
        vecs[4] = '{6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33};
        vecs[5] = '{6'h18, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33};
        vecs[6] = '{6'h1A, 32'h7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 33};
        vecs[7] = '{6'h1B, 32'd100, 32'd7, 32'd2, 32'd14, 33};
        vecs[8] = '{6'h19, 32'h10000, 32'h10000, 32'h1, 32'h0, 33};
        vecs[9] = '{6'h1A, 32'h5, 32'h0, 32'h5, 32'hFFFFFFFF, 0};

        #12;
        chk("reset_stall", {31'b0, stall}, 32'h0);
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);
        valid = 1'b1;
        funct = 6'h10;
        #1;
        chk("reset_result", result, 32'h0);
        valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].funct, vecs[i].a, vecs[i].b, cyc);
            chk($sformatf("v%0d_stall", i), cyc, vecs[i].stall);
            chk($sformatf("v%0d_hi", i), hi, vecs[i].hi);
            chk($sformatf("v%0d_lo", i), lo, vecs[i].lo);
        end

        run_op(6'h18, 32'hFFFFFFFE, 32'h3, cyc);
        valid = 1'b1;
        funct = 6'h10;
        #1;
        chk("mfhi_result", result, 32'hFFFFFFFF);
        chk("mfhi_valid", {31'b0, result_valid}, 32'h1);
        funct = 6'h12;
        #1;
        chk("mflo_result", result, 32'hFFFFFFFA);

        @(negedge clk);
        funct = 6'h11;
        op_a  = 32'h12345678;
        @(negedge clk);
        funct = 6'h10;
        #1;
        chk("mthi_result", result, 32'h12345678);
        chk("mthi_lo_kept", lo, 32'hFFFFFFFA);
        funct = 6'h13;
        op_a  = 32'hCAFEF00D;
        @(negedge clk);
        funct = 6'h12;
        #1;
        chk("mtlo_result", result, 32'hCAFEF00D);
        chk("mtlo_hi_kept", hi, 32'h12345678);
        valid = 1'b0;

        @(negedge clk);
        valid = 1'b1;
        funct = 6'h1B;
        op_a  = 32'd100;
        op_b  = 32'd7;
        @(negedge clk);
        valid = 1'b0;
        cyc = 0;
        while (stall && cyc < 200) begin
            cyc++;
            if (cyc == 10) en = 1'b0;
            if (cyc == 15) en = 1'b1;
            @(negedge clk);
        end
        en = 1'b1;
        chk("gap_stall", cyc, 38);
        chk("gap_lo", lo, 32'd14);
        chk("gap_hi", hi, 32'd2);

        @(negedge clk);
        valid = 1'b1;
        funct = 6'h18;
        op_a  = 32'd5;
        op_b  = 32'd6;
        @(negedge clk);
        funct = 6'h10;
        for (int k = 1; k < 10; k++) begin
            if (k == 5) begin
                #1;
                chk("busy_rvalid", {31'b0, result_valid}, 32'h0);
            end
            @(negedge clk);
        end
        valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_idle", {31'b0, stall}, 32'h0);
        chk("flush_hi", hi, 32'd2);
        chk("flush_lo", lo, 32'd14);
        @(negedge clk);
        chk("flush_still", {31'b0, stall}, 32'h0);

        valid = 1'b1;
        funct = 6'h18;
        op_a  = 32'd9;
        op_b  = 32'd9;
        @(negedge clk);
        valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre_rst_stall", {31'b0, stall}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_stall", {31'b0, stall}, 32'h0);
        chk("arst_hi", hi, 32'h0);
        chk("arst_lo", lo, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(6'h19, 32'd12, 32'd11, cyc);
        chk("post_rst_stall", cyc, 33);
        chk("post_rst_lo", lo, 32'd132);
        chk("post_rst_hi", hi, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Execute-stage multiply/divide unit. It sits directly downstream of the ID/EX pipeline register.
- It consumes the registered funct, operand buses and the R-type decode. It owns the architectural HI/LO registers and serves MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
- Multiply and divide are iterative, one bit per cycle. o_stall freezes the IF/ID and ID/EX registers (via their i_enable) while an operation runs.

Parameters:
- BUS_SIZE, 32, operand/HI/LO width; iteration count equals BUS_SIZE.

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous active-low reset
- i_enable  in  1  global pipeline enable (debug step); when low, all state holds
- i_flush  in  1  synchronous abort of an in-flight operation
- i_valid  in  1  ID/EX holds an R-type instruction (alu_op decodes to R-type)
- i_funct  in  6  ID/EX funct field
- i_op_a  in  BUS_SIZE  forwarded rs operand
- i_op_b  in  BUS_SIZE  forwarded rt operand
- o_stall  out  1  unit busy; upstream must hold
- o_result  out  BUS_SIZE  MFHI→HI, MFLO→LO, else 0 (combinational from registers)
- o_result_valid  out  1  current ID/EX instruction is MFHI/MFLO and unit idle
- o_hi  out  BUS_SIZE  HI register
- o_lo  out  BUS_SIZE  LO register

Behaviour:
- Reset (i_reset_n low, asynchronous): state=IDLE, HI=0, LO=0, counter=0, all internal accumulators 0. Outputs follow: o_stall=0, o_result=0, o_result_valid=0.
- Funct codes:
  - MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13
  - MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B
  - Any other funct: no effect.
- Nothing advances while i_enable=0, including RUN iterations.
- States:
  - IDLE → RUN: on an edge with i_enable & i_valid & funct∈{MULT,MULTU,DIV,DIVU} and divisor≠0 for DIV/DIVU.
    - Latch |a|, |b| (signed ops) or raw values, plus result-sign flags. Counter=0.
  - IDLE, MTHI/MTLO: HI (resp. LO) ← i_op_a on that edge. State stays IDLE.
  - IDLE, DIV/DIVU with i_op_b==0: no iteration. On the same edge LO←all-ones and HI←i_op_a. State stays IDLE and o_stall is never asserted.
  - RUN: one iteration per enabled edge, counter+1. After BUS_SIZE iterations, go to FIX.
    - Multiply: shift-add into a 2·BUS_SIZE product.
    - Divide: restoring divide; quotient and remainder registers.
  - FIX: one edge applies the sign fix, then writes the result and returns to IDLE.
    - Multiply: 2's-complement the product if signs differ. HI=upper half, LO=lower half.
    - Divide: negate the quotient if signs differ; the remainder takes the dividend sign. LO=quotient, HI=remainder.
- Latency: the start edge plus BUS_SIZE RUN edges plus 1 FIX edge. With BUS_SIZE=32, o_stall=1 for exactly 33 cycles after the start edge, and HI/LO are visible the cycle o_stall falls.
- o_stall = (state≠IDLE), a registered-state decode with no combinational path from i_valid/i_funct.
- MFHI/MFLO while o_stall=1 cannot occur: the pipeline is frozen. o_result_valid is forced to 0 while o_stall=1.
- i_flush:
  - In RUN/FIX: go to IDLE at the next edge. HI/LO unchanged; partial result discarded.
  - In IDLE: suppresses the start/MT write on that edge.
  - i_flush takes priority over i_valid.
- Signed overflow case 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (natural wrap of the absolute-value path).
- Reset asserted mid-operation: immediate return to the reset values above.

Decomposition:
- Shared header (mips_funct.vh, alongside the existing pipeline headers) holds:
  - funct codes
  - state encodings (IDLE=2'b00, RUN=2'b01, FIX=2'b10)
  - the CLEAR/LOW helpers
- One natural sub-module, muldiv_core: the iteration datapath (counter, accumulators, sign fix). ex_muldiv keeps decode, HI/LO, the FSM and the stall logic.

Test Plan:
- MULT a=0xFFFFFFFE (−2), b=3: o_stall high 33 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MFHI next gives o_result=0xFFFFFFFF, o_result_valid=1.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF: HI=0xFFFFFFFE, LO=0x00000001.
- DIV a=−7 (0xFFFFFFF9), b=2: LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). Then DIVU a=7, b=0: no stall, LO=0xFFFFFFFF, HI=7 on the same edge.
- MTHI 0x12345678 then MFHI: o_result=0x12345678; LO unchanged.
- DIVU 100/7 started, i_enable dropped for 5 cycles mid-RUN: o_stall lasts 33+5 cycles; LO=14, HI=2.
- MULT started, i_flush at RUN cycle 10: IDLE next cycle, HI/LO keep their prior values. Separately, i_reset_n pulsed low mid-RUN: asynchronous return to IDLE with HI=LO=0.
